rob_commit_ctrl: RTL and testbench
==================================

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of reorder buffer entries; the pointer width PW = log2(DEPTH), which is 3 at the default.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alloc_req  input  1  the instruction handler requests an entry for the instruction currently on the shared instruction bus.
REQ-005 alloc_ack  output  1  combinational; the request is accepted this cycle.
REQ-006 sel  output  DEPTH  combinational, one-hot; drives the sel input of the entry at the tail.
REQ-007 head  output  PW  registered; index of the oldest entry, broadcast to every entry's head input.
REQ-008 entry_busy  input  DEPTH  busy output of each entry.
REQ-009 entry_wen  input  DEPTH  wen output of each entry.
REQ-010 entry_dest  input  5*DEPTH  dest of each entry; entry i occupies bits [5i+4:5i].
REQ-011 entry_value  input  32*DEPTH  result value of each entry; entry i occupies bits [32i+31:32i].
REQ-012 rf_we, rf_waddr, rf_wdata  output  1/5/32  registered register-file write port.
REQ-013 count  output  PW+1  registered occupancy; full and empty are combinational status outputs derived from it.
REQ-014 err  output  1  registered, sticky protocol-error flag.

Function
REQ-015 Allocation accepted when alloc_req=1 and full=0:
- alloc_ack=1, and sel has the tail bit set in that same cycle;
- tail advances by one at the next edge.
REQ-016 When full=1 or alloc_req=0: alloc_ack=0, sel=0, tail unchanged.
REQ-017 Pointers wrap modulo DEPTH: with DEPTH=8, tail 7 goes to 0 and head 7 goes to 0.
REQ-018 Shadow capture: each cycle that entry_wen[head]=0, the controller captures entry_dest[head] and entry_value[head] into a shadow register.
- Reason: an entry clears its dest in the same edge that it raises wen.
REQ-019 Commit event: entry_wen[head]=1 and empty=0. At the next edge:
- head advances by one;
- rf_we=1, rf_waddr=shadow dest, rf_wdata=shadow value.
REQ-020 rf_we is a single-cycle pulse; it returns to 0 on the following edge unless another commit event occurs.
REQ-021 Commit with shadow dest = 0 (register x0): head still advances and count still decrements, but rf_we stays 0.
REQ-022 Commit latency: one cycle from entry_wen[head] rising to rf_we=1, so at most one commit per cycle.
REQ-023 count update at each edge:
- +1 on allocation only;
- -1 on commit only;
- unchanged when allocation and commit occur in the same cycle;
- full = (count == DEPTH), empty = (count == 0), both from the registered count only.
REQ-024 An allocation and a commit in the same cycle while full=1 is refused; the slot being freed is reused no earlier than the next cycle.
REQ-025 Protocol errors set err=1 at the next edge:
- entry_wen[i]=1 for any i other than head;
- entry_wen asserted while empty=1;
- sel targets an entry whose entry_busy is 1.
REQ-026 Error handling:
- the erroneous event is otherwise ignored (no pointer, count or register-file change);
- err clears only on rst.
REQ-027 Invariants:
- count never exceeds DEPTH and never underflows;
- sel is never multi-hot.

Reset
REQ-028 While rst=1 at an edge, all registered outputs and state go to these values:
- head=0, tail=0, count=0, so empty=1 and full=0;
- rf_we=0, rf_waddr=0, rf_wdata=0;
- err=0, shadow register = 0.
REQ-029 Reset has priority over any allocation or commit in the same cycle.
- An in-flight commit is discarded: no rf_we pulse after reset.
REQ-030 While rst=1, alloc_ack=0 and sel=0.

Verification
REQ-031 Basic commit: after reset, allocate one entry (sel=8'b0000_0001). Entry 0 presents dest=5, value=0xDEADBEEF, then raises wen → one cycle later rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, head=1, count=0.
REQ-032 Full and wrap: allocate 8 entries → full=1 and a 9th alloc_req gives alloc_ack=0. Then commit entries 0–7 in order → head wraps to 0, empty=1, and 8 rf_we pulses in order.
REQ-033 Simultaneous events: with count=3, assert alloc_req and entry_wen[head] in the same cycle → count stays 3, head+1, tail+1, rf_we=1.
REQ-034 x0 and error: commit an entry with dest=0 → rf_we stays 0 and head advances. Then pulse entry_wen[head+2] → err=1, head unchanged.
REQ-035 Reset mid-operation: with count=5, assert rst in the same cycle as entry_wen[head] → next cycle head=0, count=0, rf_we=0, err=0.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer commit controller.
// Allocates entries at the tail, retires the oldest entry at the head into
// the register file, and tracks occupancy and protocol errors.
//
// Allocation handshake: alloc_req is the request and alloc_ack is the grant.
// A transfer happens in exactly the cycle in which both are high, and sel
// marks the granted entry in that same cycle. alloc_ack never depends on
// anything registered later, and the requester may drop alloc_req at any time.
module rob_commit_ctrl #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  output logic                alloc_ack,
  output logic [DEPTH-1:0]    sel,
  output logic [PW-1:0]       head,
  input  logic [DEPTH-1:0]    entry_busy,
  input  logic [DEPTH-1:0]    entry_wen,
  input  logic [5*DEPTH-1:0]  entry_dest,
  input  logic [32*DEPTH-1:0] entry_value,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [PW:0]         count,
  output logic                full,
  output logic                empty,
  output logic                err
);

  localparam logic [PW:0]       DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]       CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0]     PTR_ONE = PW'(1);
  localparam logic [PW-1:0]     PTR_LAST = PW'(DEPTH - 1);
  localparam logic [DEPTH-1:0]  OH_ONE = DEPTH'(1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          err_q, err_d;
  logic [4:0]    shadow_dest_q, shadow_dest_d;
  logic [31:0]   shadow_value_q, shadow_value_d;

  logic [DEPTH-1:0] head_oh;
  logic [DEPTH-1:0] tail_oh;
  logic [4:0]       head_dest;
  logic [31:0]      head_value;
  logic             alloc_ok;
  logic             err_other;
  logic             err_empty;
  logic             err_busy;
  logic             proto_err;
  logic             do_alloc;
  logic             do_commit;

  // Status decode, allocation grant and protocol-error detection.
  always_comb begin
    head_oh    = OH_ONE << head_q;
    tail_oh    = OH_ONE << tail_q;
    head_dest  = entry_dest[int'(head_q)*5 +: 5];
    head_value = entry_value[int'(head_q)*32 +: 32];
    full       = (count_q == DEPTH_C);
    empty      = (count_q == '0);
    // Full blocks allocation even if the head retires this cycle, so a
    // freed slot is only reused from the next cycle on.
    alloc_ok   = alloc_req & ~full & ~rst;
    alloc_ack  = alloc_ok;
    sel        = alloc_ok ? tail_oh : '0;
    err_other  = |(entry_wen & ~head_oh);
    err_empty  = empty & (|entry_wen);
    err_busy   = alloc_ok & (|(tail_oh & entry_busy));
    proto_err  = err_other | err_empty | err_busy;
    // Any protocol error freezes pointers, count and the register-file port.
    do_alloc   = alloc_ok & ~proto_err;
    do_commit  = entry_wen[head_q] & ~empty & ~proto_err;
  end

  // Next-state computation for pointers, occupancy, shadow and write port.
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    err_d          = err_q | proto_err;
    shadow_dest_d  = shadow_dest_q;
    shadow_value_d = shadow_value_q;

    // The entry zeroes its dest on the same edge it raises wen, so the
    // retiring dest/value come from the copy taken while wen was still low.
    if (!entry_wen[head_q]) begin
      shadow_dest_d  = head_dest;
      shadow_value_d = head_value;
    end

    if (do_alloc) begin
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_ONE;
    end

    if (do_commit) begin
      head_d     = (head_q == PTR_LAST) ? '0 : head_q + PTR_ONE;
      // x0 is hardwired to zero: retire the entry but skip the write.
      rf_we_d    = (shadow_dest_q != 5'd0);
      rf_waddr_d = shadow_dest_q;
      rf_wdata_d = shadow_value_q;
    end

    if (do_alloc && !do_commit) begin
      count_d = count_q + CNT_ONE;
    end else if (do_commit && !do_alloc) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // State registers with synchronous reset taking priority over any event.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      err_q          <= 1'b0;
      shadow_dest_q  <= '0;
      shadow_value_q <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      err_q          <= err_d;
      shadow_dest_q  <= shadow_dest_d;
      shadow_value_q <= shadow_value_d;
    end
  end

  assign head     = head_q;
  assign count    = count_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: a small entry model drives the
// per-entry inputs, expected register-file writes go into exp_q and a
// negedge monitor pops them as rf_we pulses appear.
module tb_rob_commit_ctrl;

  localparam int DEPTH = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         alloc_req = 1'b0;
  logic         alloc_ack;
  logic [7:0]   sel;
  logic [2:0]   head;
  logic [7:0]   entry_busy = '0;
  logic [7:0]   entry_wen = '0;
  logic [39:0]  entry_dest = '0;
  logic [255:0] entry_value = '0;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [3:0]   count;
  logic         full;
  logic         empty;
  logic         err;

  rob_commit_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ack(alloc_ack),
    .sel(sel), .head(head), .entry_busy(entry_busy), .entry_wen(entry_wen),
    .entry_dest(entry_dest), .entry_value(entry_value), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .count(count), .full(full),
    .empty(empty), .err(err)
  );

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  // Bench-side model of the pointers and occupancy.
  int hd_m = 0;
  int tl_m = 0;
  int cnt_m = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every rf_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rf_we_unexpected", 64'(rf_we), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rf_waddr", 64'(rf_waddr), 64'(e[36:32]));
        check("rf_wdata", 64'(rf_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    alloc_req = 1'b1;
    #1;
    check("rst_ack", 64'(alloc_ack), 64'd0);
    check("rst_sel", 64'(sel), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    alloc_req = 1'b0;
    entry_wen = '0;
    entry_busy = '0;
    hd_m = 0;
    tl_m = 0;
    cnt_m = 0;
  endtask

  task automatic do_alloc();
    logic [7:0] oh;
    oh = 8'd1 << tl_m;
    alloc_req = 1'b1;
    #1;
    check("alloc_ack", 64'(alloc_ack), 64'd1);
    check("alloc_sel", 64'(sel), 64'(oh));
    tick();
    alloc_req = 1'b0;
    entry_busy[tl_m] = 1'b1;
    tl_m = (tl_m + 1) % DEPTH;
    cnt_m++;
    check("alloc_count", 64'(count), 64'(cnt_m));
  endtask

  // Entry at head presents dest/value, then raises wen while clearing dest.
  task automatic do_commit(input logic [4:0] d, input logic [31:0] v, input bit with_alloc);
    int i;
    bit acc;
    logic [7:0] oh;
    i = hd_m;
    entry_dest[i*5 +: 5] = d;
    entry_value[i*32 +: 32] = v;
    tick();
    entry_wen[i] = 1'b1;
    entry_dest[i*5 +: 5] = 5'd0;
    entry_value[i*32 +: 32] = $urandom;
    acc = 1'b0;
    if (with_alloc) begin
      alloc_req = 1'b1;
      #1;
      acc = (cnt_m != DEPTH);
      oh = acc ? (8'd1 << tl_m) : 8'd0;
      check("cm_alloc_ack", 64'(alloc_ack), 64'(acc));
      check("cm_alloc_sel", 64'(sel), 64'(oh));
    end
    if (d != 5'd0) exp_q.push_back({d, v});
    tick();
    entry_wen[i] = 1'b0;
    alloc_req = 1'b0;
    entry_busy[i] = 1'b0;
    hd_m = (hd_m + 1) % DEPTH;
    cnt_m--;
    if (acc) begin
      entry_busy[tl_m] = 1'b1;
      tl_m = (tl_m + 1) % DEPTH;
      cnt_m++;
    end
    check("cm_head", 64'(head), 64'(hd_m));
    check("cm_count", 64'(count), 64'(cnt_m));
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_head", 64'(head), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // Basic commit
    do_alloc();
    do_commit(5'd5, 32'hDEADBEEF, 1'b0);
    check("basic_rf_we", 64'(rf_we), 64'd1);
    check("basic_waddr", 64'(rf_waddr), 64'd5);
    check("basic_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("basic_head", 64'(head), 64'd1);
    tick();
    check("rf_we_pulse", 64'(rf_we), 64'd0);

    // Full and wrap, including refused alloc while full during a commit
    do_reset();
    for (int k = 0; k < DEPTH; k++) do_alloc();
    check("full_flag", 64'(full), 64'd1);
    alloc_req = 1'b1;
    #1;
    check("full_ack", 64'(alloc_ack), 64'd0);
    check("full_sel", 64'(sel), 64'd0);
    tick();
    alloc_req = 1'b0;
    check("full_count", 64'(count), 64'd8);
    do_commit(5'd1, $urandom, 1'b1);
    for (int k = 1; k < DEPTH; k++) do_commit(5'(k + 1), $urandom, 1'b0);
    check("wrap_head", 64'(head), 64'd0);
    check("wrap_empty", 64'(empty), 64'd1);

    // Simultaneous allocation and commit with count=3
    for (int k = 0; k < 3; k++) do_alloc();
    do_commit(5'd7, $urandom, 1'b1);
    check("sim_count", 64'(count), 64'd3);

    // x0 commit, then wen on a non-head entry
    do_commit(5'd0, 32'h12345678, 1'b0);
    check("x0_rf_we", 64'(rf_we), 64'd0);
    entry_wen[(hd_m + 2) % DEPTH] = 1'b1;
    tick();
    entry_wen = '0;
    check("err_other", 64'(err), 64'd1);
    check("err_head", 64'(head), 64'(hd_m));
    check("err_count", 64'(count), 64'(cnt_m));
    tick();
    check("err_sticky", 64'(err), 64'd1);

    // wen while empty
    do_reset();
    entry_wen[0] = 1'b1;
    tick();
    entry_wen = '0;
    check("err_empty", 64'(err), 64'd1);
    check("err_empty_count", 64'(count), 64'd0);

    // sel onto a busy entry
    do_reset();
    entry_busy[0] = 1'b1;
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    check("err_busy", 64'(err), 64'd1);
    check("err_busy_count", 64'(count), 64'd0);

    // Reset mid-operation discards the in-flight commit
    do_reset();
    for (int k = 0; k < 5; k++) do_alloc();
    entry_dest[hd_m*5 +: 5] = 5'd9;
    entry_value[hd_m*32 +: 32] = $urandom;
    tick();
    entry_wen[hd_m] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    entry_wen = '0;
    entry_busy = '0;
    check("rmid_head", 64'(head), 64'd0);
    check("rmid_count", 64'(count), 64'd0);
    check("rmid_rf_we", 64'(rf_we), 64'd0);
    check("rmid_err", 64'(err), 64'd0);
    tick();
    check("rmid_rf_we2", 64'(rf_we), 64'd0);

    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
